// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: one bit cell per clock, LSB-first (always WIDTH cycles)
// or MSB-first (stops at the first differing bit), unsigned or two's-complement.
module serial_comparator #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             signed_cmp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [1:0] P_EQ = 2'b00;
  localparam logic [1:0] P_GT = 2'b01;
  localparam logic [1:0] P_LT = 2'b10;

  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             dir_q, dir_d, sgn_q, sgn_d;
  logic [1:0]       p_q, p_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic             done_q, done_d;

  logic       bit_a, bit_b, diff, a_wins, last;
  logic [1:0] p_cell;

  // The sign bit carries negative weight, so a set MSB makes that operand smaller.
  always_comb begin
    bit_a  = a_q[idx_q];
    bit_b  = b_q[idx_q];
    diff   = bit_a ^ bit_b;
    a_wins = (sgn_q && (idx_q == IDX_MSB)) ? bit_b : bit_a;
    p_cell = diff ? (a_wins ? P_GT : P_LT) : p_q;
    last   = dir_q ? (diff || (idx_q == '0)) : (idx_q == IDX_MSB);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    dir_d   = dir_q;
    sgn_d   = sgn_q;
    p_d     = p_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    done_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        cyc_d = cyc_q + CW'(1);
        p_d   = p_cell;
        if (last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          gt_d    = (p_cell == P_GT);
          lt_d    = (p_cell == P_LT);
          eq_d    = (p_cell == P_EQ);
        end else begin
          idx_d = dir_q ? (idx_q - IW'(1)) : (idx_q + IW'(1));
        end
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          dir_d   = dir;
          sgn_d   = signed_cmp;
          p_d     = P_EQ;
          idx_d   = dir ? IDX_MSB : '0;
          cyc_d   = '0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dir_q   <= 1'b0;
      sgn_q   <= 1'b0;
      p_q     <= P_EQ;
      idx_q   <= '0;
      cyc_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dir_q   <= dir_d;
      sgn_q   <= sgn_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = done_q;
  assign gt     = gt_q;
  assign lt     = lt_q;
  assign eq     = eq_q;
  assign cycles = cyc_q;

endmodule
